// File: rtl/bp_fe_ras_pkg.sv
// Shared RAS types: opcode constants, link-register test, checkpoint layout and decoded op.
// Build option BP_FE_RAS_PERF_CNT_EN (see bp_fe_ras_ckpt) does not change anything here.
package bp_fe_ras_pkg;

    localparam int ras_idx_width_gp = 4;

    localparam logic [6:0] opcode_jal_gp    = 7'h6F;
    localparam logic [6:0] opcode_jalr_gp   = 7'h67;
    localparam logic [2:0] funct3_jalr_gp   = 3'b000;

    typedef struct packed {
        logic [ras_idx_width_gp-1:0] top_ptr;
        logic [ras_idx_width_gp:0]   count;
    } ras_ckpt_s;

    typedef enum logic [1:0] {
        RAS_NONE,
        RAS_PUSH,
        RAS_POP,
        RAS_SWAP
    } ras_op_e;

    function automatic logic is_link(input logic [4:0] reg_idx);
        return (reg_idx == 5'd1) || (reg_idx == 5'd5);
    endfunction

endpackage

// File: rtl/bp_fe_ras_decode.sv
// Purpose: classify a fetched instruction as RAS push / pop / swap / none.
// Latency: combinational. Backpressure: none, pure function of instr_i.
module bp_fe_ras_decode
    import bp_fe_ras_pkg::*;
(
    input  logic [31:0] instr_i,
    output ras_op_e     op_o
);

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [11:0] imm;
    logic        rd_link;
    logic        rs1_link;

    assign opcode   = instr_i[6:0];
    assign rd       = instr_i[11:7];
    assign funct3   = instr_i[14:12];
    assign rs1      = instr_i[19:15];
    assign imm      = instr_i[31:20];
    assign rd_link  = is_link(rd);
    assign rs1_link = is_link(rs1);

    always_comb begin
        op_o = RAS_NONE;
        if (opcode == opcode_jal_gp) begin
            if (rd_link) op_o = RAS_PUSH;
        end else if (opcode == opcode_jalr_gp && funct3 == funct3_jalr_gp) begin
            // Swap must win over push: both link regs but different is a coroutine hop
            if (rd_link && rs1_link && rd != rs1)
                op_o = RAS_SWAP;
            else if (rd_link)
                op_o = RAS_PUSH;
            else if (rd == 5'd0 && rs1_link && imm == 12'd0)
                op_o = RAS_POP;
        end
    end

endmodule

// File: rtl/bp_fe_ras_ckpt.sv
// Purpose: checkpointable return-address stack; BP_FE_RAS_PERF_CNT_EN adds overflow/underflow counters.
// Latency: prediction and ckpt_o are 0-cycle combinational; stack updates on the next clk_i edge.
// Backpressure: none; redirect_v_i overrides any fetch in the same cycle.
module bp_fe_ras_ckpt
    import bp_fe_ras_pkg::*;
#(
    parameter int eaddr_width_p    = 32,
    parameter int ras_idx_width_p  = ras_idx_width_gp,
    parameter int instr_bytes_p    = 4,
    parameter int perf_cnt_width_p = 16
)
(
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         fetch_v_i,
    input  logic [31:0]                  instr_i,
    input  logic [eaddr_width_p-1:0]     pc_i,
    input  logic                         redirect_v_i,
    input  logic [2*ras_idx_width_p:0]   redirect_ckpt_i,
`ifdef BP_FE_RAS_PERF_CNT_EN
    output logic [perf_cnt_width_p-1:0]  ovf_cnt_o,
    output logic [perf_cnt_width_p-1:0]  unf_cnt_o,
`endif
    output logic [eaddr_width_p-1:0]     pc_o,
    output logic                         pc_v_o,
    output logic [2*ras_idx_width_p:0]   ckpt_o
);

    localparam int depth_lp = 1 << ras_idx_width_p;
    localparam logic [ras_idx_width_p:0] depth_cnt_lp = (ras_idx_width_p+1)'(depth_lp);

    typedef logic [perf_cnt_width_p-1:0] perf_cnt_t;

    logic [ras_idx_width_p-1:0] top_ptr_r;
    logic [ras_idx_width_p:0]   count_r;
    logic [eaddr_width_p-1:0]   stack_r [depth_lp];

    ras_op_e                    dec_op;
    ras_op_e                    op;
    logic [eaddr_width_p-1:0]   ret_addr;
    logic [ras_idx_width_p-1:0] top_inc;
    logic                       empty;
    logic                       full;
    logic                       push_v;
    logic                       pop_v;
    logic                       swap_v;

    bp_fe_ras_decode u_decode (
        .instr_i (instr_i),
        .op_o    (dec_op)
    );

    assign op       = fetch_v_i ? dec_op : RAS_NONE;
    assign ret_addr = pc_i + eaddr_width_p'(instr_bytes_p);
    assign top_inc  = top_ptr_r + ras_idx_width_p'(1);
    assign empty    = (count_r == '0);
    assign full     = (count_r == depth_cnt_lp);

    // A swap on an empty stack has nothing to replace, so it degenerates into a push
    assign push_v = ~redirect_v_i & ((op == RAS_PUSH) | ((op == RAS_SWAP) & empty));
    assign pop_v  = ~redirect_v_i & (op == RAS_POP)  & ~empty;
    assign swap_v = ~redirect_v_i & (op == RAS_SWAP) & ~empty;

    assign pc_o   = stack_r[top_ptr_r];
    assign pc_v_o = ~redirect_v_i & ~empty & ((op == RAS_POP) | (op == RAS_SWAP));
    assign ckpt_o = {top_ptr_r, count_r};

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            top_ptr_r <= '1;
            count_r   <= '0;
            for (int i = 0; i < depth_lp; i++) stack_r[i] <= '0;
        end else if (redirect_v_i) begin
            top_ptr_r <= redirect_ckpt_i[2*ras_idx_width_p:ras_idx_width_p+1];
            count_r   <= redirect_ckpt_i[ras_idx_width_p:0];
        end else if (push_v) begin
            // When full the pointer wraps onto the oldest entry and overwrites it
            top_ptr_r        <= top_inc;
            stack_r[top_inc] <= ret_addr;
            if (!full) count_r <= count_r + 1'b1;
        end else if (pop_v) begin
            top_ptr_r <= top_ptr_r - ras_idx_width_p'(1);
            count_r   <= count_r - 1'b1;
        end else if (swap_v) begin
            stack_r[top_ptr_r] <= ret_addr;
        end
    end

`ifdef BP_FE_RAS_PERF_CNT_EN
    perf_cnt_t ovf_cnt_r;
    perf_cnt_t unf_cnt_r;
    logic      ovf_inc;
    logic      unf_inc;

    assign ovf_inc = ~redirect_v_i & (op == RAS_PUSH) & full;
    assign unf_inc = ~redirect_v_i & (op == RAS_POP)  & empty;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ovf_cnt_r <= '0;
            unf_cnt_r <= '0;
        end else begin
            if (ovf_inc && ovf_cnt_r != '1) ovf_cnt_r <= ovf_cnt_r + 1'b1;
            if (unf_inc && unf_cnt_r != '1) unf_cnt_r <= unf_cnt_r + 1'b1;
        end
    end

    assign ovf_cnt_o = ovf_cnt_r;
    assign unf_cnt_o = unf_cnt_r;
`endif

endmodule
